uart_transmitter: RTL and testbench
===================================

// Module: uart_transmitter
// PURPOSE
//  8N1 UART transmit stage: buffers parallel bytes in a small FIFO and serialises them onto SerialOut.
//  Sits directly upstream of the serial receiver and drives its SerialIn pin.
//  Bit timing matches the receiver: 50 MHz Clock, one bit = CLKS_PER_BIT cycles.
// PARAMETERS
//  CLKS_PER_BIT  5028  Clock cycles per serial bit; must match the receiver's bit period.
//  DATA_BITS     8     Payload bits per frame, sent LSB first.
//  FIFO_DEPTH    4     Byte buffer entries; must be a power of 2 and at least 2.
// PORTS
//  Clock      in   1          System clock, 50 MHz.
//  Reset      in   1          Asynchronous, active-low reset (0 = reset).
//  TxData     in   DATA_BITS  Byte to send; sampled when TxValid && TxReady.
//  TxValid    in   1          Producer presents TxData.
//  TxReady    out  1          FIFO not full.
//  SerialOut  out  1          UART line; idles high.
//  Busy       out  1          High while a frame is on the line or the FIFO is non-empty.
//  FifoCount  out  clog2(D)+1 Number of bytes currently buffered.
// BEHAVIOUR
//  Reset values (Reset low, immediate): SerialOut=1, Busy=0, FifoCount=0, TxReady=1, FSM=IDLE, all counters 0.
//  Handshake:
//   - Write occurs on a rising edge with TxValid && TxReady.
//   - TxReady = !full, combinational from the registered count.
//   - TxValid while full is ignored: no write, no error.
//  FSM states: IDLE, START, DATA, STOP.
//   - IDLE: SerialOut=1. If the FIFO is non-empty, pop the head into the shift register, go to START.
//   - START: SerialOut=0 for CLKS_PER_BIT cycles, then go to DATA.
//   - DATA: SerialOut=shift[0]; after each CLKS_PER_BIT cycles shift right.
//     After DATA_BITS bits, go to STOP.
//   - STOP: SerialOut=1 for CLKS_PER_BIT cycles.
//     Then, if the FIFO is non-empty, pop and go straight to START (back-to-back frames, no idle gap); else go to IDLE.
//  Timing:
//   - Frame length is exactly (DATA_BITS+2)*CLKS_PER_BIT cycles.
//   - Latency from a write into an empty FIFO in IDLE to the SerialOut falling edge: 2 cycles (write, then pop).
//  Counters:
//   - Bit-period counter runs 0..CLKS_PER_BIT-1 and wraps.
//   - Bit index runs 0..DATA_BITS-1.
//   - Both reset on every state entry.
//  SerialOut is driven from a flop (glitch-free).
//  FIFO:
//   - Read/write pointers of width clog2(D), wrap modulo D.
//   - Full when count==D; empty when count==0.
//  Simultaneous push and pop in one cycle: both take effect, count unchanged. When full, pop frees space only from the next cycle.
//  Busy = (state!=IDLE) || (count!=0).
//  Reset mid-frame: the frame is abandoned; line returns high immediately; FIFO contents are discarded.
// STRUCTURE
//  Shared package uart_pkg holds:
//   - tx_state_t enum {IDLE, START, DATA, STOP}.
//   - UART_CLKS_PER_BIT = 5028 and UART_DATA_BITS = 8, so TX and RX share one timing source.
//  Sub-module uart_tx_fifo, a synchronous-write FIFO:
//   - Parameters: DATA_BITS, FIFO_DEPTH.
//   - Ports: push, pop, din, dout, full, empty, count.
//  The top level contains the FSM, bit-period counter, bit index and shift register.
// TESTING (sim with CLKS_PER_BIT=4 unless noted)
//  1. Reset then idle 100 cycles -> SerialOut=1, Busy=0, TxReady=1, FifoCount=0 throughout.
//  2. Write 0xA5 once -> SerialOut falls 2 cycles later.
//     Line then carries 0,1,0,1,0,0,1,0,1,1, 4 cycles each; Busy drops after 40 cycles.
//  3. Write 0x00,0xFF,0x3C,0x81,0x55 with TxValid held high.
//     -> TxReady low once 4 are buffered; all 5 frames sent back-to-back with no idle bit; bytes arrive in order.
//  4. Push and pop in the same cycle at count=1 -> FifoCount stays 1; no byte lost or duplicated.
//  5. Assert Reset in the DATA state, bit 3 of 0xF0 -> SerialOut=1 immediately and FifoCount=0.
//     After release, IDLE with no spurious start bit.
//  6. Loopback into the receiver, CLKS_PER_BIT=5028, send 0x5A and 0xC3 -> receiver shows UpdatePulse and ReceivedData equal to each byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter FSM states and the bit timing
// used by both the transmitter and the receiver.
package uart_pkg;

    // One serial bit lasts this many 50 MHz clock cycles (both directions).
    localparam int UART_CLKS_PER_BIT = 5028;
    // Payload bits carried in one 8N1 frame.
    localparam int UART_DATA_BITS    = 8;
    // Default depth of the transmit byte buffer.
    localparam int UART_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Width of a counter that must hold values 0..n-1 (at least one bit).
    function automatic int cntWidth(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small byte buffer in front of the UART serialiser. Writes are synchronous;
// the head entry is always visible on dout so the serialiser can load it on
// the same edge that it pops. Push is ignored when full, pop when empty.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int FIFO_DEPTH = UART_FIFO_DEPTH
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_BITS-1:0]         din,
    output logic [DATA_BITS-1:0]         dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(FIFO_DEPTH):0]  count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]     wrPtr_r;
    logic [PTR_W-1:0]     rdPtr_r;
    logic [CNT_W-1:0]     count_r;
    logic                 wrEn_s;
    logic                 rdEn_s;

    // Full/empty come straight from the registered count, so space freed by
    // a pop is only offered to the producer from the following cycle.
    assign full   = (count_r == DEPTH_CNT);
    assign empty  = (count_r == CNT_W'(0));
    assign count  = count_r;
    assign dout   = mem_r[rdPtr_r];

    // Qualify requests so a full buffer never overwrites and an empty one never underflows.
    always_comb begin
        wrEn_s = 1'b0;
        rdEn_s = 1'b0;
        if (push && !full) begin
            wrEn_s = 1'b1;
        end else begin
            wrEn_s = 1'b0;
        end
        if (pop && !empty) begin
            rdEn_s = 1'b1;
        end else begin
            rdEn_s = 1'b0;
        end
    end

    // Storage array: no reset needed, stale entries are unreachable once pointers clear.
    always_ff @(posedge Clock) begin
        if (wrEn_s) begin
            mem_r[wrPtr_r] <= din;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wrPtr_r <= PTR_W'(0);
            rdPtr_r <= PTR_W'(0);
        end else begin
            if (wrEn_s) begin
                wrPtr_r <= wrPtr_r + PTR_W'(1);
            end
            if (rdEn_s) begin
                rdPtr_r <= rdPtr_r + PTR_W'(1);
            end
        end
    end

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_r <= CNT_W'(0);
        end else begin
            case ({wrEn_s, rdEn_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter. Bytes are buffered in uart_tx_fifo and serialised
// LSB first as start bit, DATA_BITS payload bits, stop bit, each lasting
// CLKS_PER_BIT clocks. Queued frames follow each other with no idle gap.
// SerialOut comes from a flop that is loaded from the next state, so the
// line changes on exactly the edge on which the FSM changes state.
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int DATA_BITS    = UART_DATA_BITS,
    parameter int FIFO_DEPTH   = UART_FIFO_DEPTH
) (
    input  logic                         Clock,
    input  logic                         Reset,
    input  logic [DATA_BITS-1:0]         TxData,
    input  logic                         TxValid,
    output logic                         TxReady,
    output logic                         SerialOut,
    output logic                         Busy,
    output logic [$clog2(FIFO_DEPTH):0]  FifoCount
);

    localparam int CNT_W = cntWidth(CLKS_PER_BIT);
    localparam int IDX_W = cntWidth(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_t                    state_r;
    tx_state_t                    nextState_s;
    logic [CNT_W-1:0]             bitCnt_r;
    logic [CNT_W-1:0]             bitCntNext_s;
    logic [IDX_W-1:0]             bitIdx_r;
    logic [IDX_W-1:0]             bitIdxNext_s;
    logic [DATA_BITS-1:0]         shift_r;
    logic [DATA_BITS-1:0]         shiftNext_s;
    logic                         serialOut_r;
    logic                         serialNext_s;
    logic                         bitDone_s;

    logic                         fifoPush_s;
    logic                         fifoPop_s;
    logic                         fifoFull_s;
    logic                         fifoEmpty_s;
    logic [DATA_BITS-1:0]         fifoDout_s;
    logic [$clog2(FIFO_DEPTH):0]  fifoCount_s;

    assign fifoPush_s = TxValid && !fifoFull_s;
    assign bitDone_s  = (bitCnt_r == LAST_CNT);

    assign TxReady    = !fifoFull_s;
    assign SerialOut  = serialOut_r;
    assign Busy       = (state_r != IDLE) || !fifoEmpty_s;
    assign FifoCount  = fifoCount_s;

    uart_tx_fifo #(
        .DATA_BITS  (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .Clock (Clock),
        .Reset (Reset),
        .push  (fifoPush_s),
        .pop   (fifoPop_s),
        .din   (TxData),
        .dout  (fifoDout_s),
        .full  (fifoFull_s),
        .empty (fifoEmpty_s),
        .count (fifoCount_s)
    );

    // Next-state logic: bit timing, payload shifting and FIFO pops.
    always_comb begin
        nextState_s  = state_r;
        bitCntNext_s = bitCnt_r + CNT_W'(1);
        bitIdxNext_s = bitIdx_r;
        shiftNext_s  = shift_r;
        fifoPop_s    = 1'b0;

        case (state_r)
            IDLE: begin
                bitCntNext_s = CNT_W'(0);
                bitIdxNext_s = IDX_W'(0);
                if (!fifoEmpty_s) begin
                    fifoPop_s   = 1'b1;
                    shiftNext_s = fifoDout_s;
                    nextState_s = START;
                end else begin
                    nextState_s = IDLE;
                end
            end

            START: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_W'(0);
                    bitIdxNext_s = IDX_W'(0);
                    nextState_s  = DATA;
                end else begin
                    nextState_s  = START;
                end
            end

            DATA: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_W'(0);
                    if (bitIdx_r == LAST_IDX) begin
                        bitIdxNext_s = IDX_W'(0);
                        nextState_s  = STOP;
                    end else begin
                        bitIdxNext_s = bitIdx_r + IDX_W'(1);
                        shiftNext_s  = {1'b0, shift_r[DATA_BITS-1:1]};
                        nextState_s  = DATA;
                    end
                end else begin
                    nextState_s = DATA;
                end
            end

            STOP: begin
                if (bitDone_s) begin
                    bitCntNext_s = CNT_W'(0);
                    bitIdxNext_s = IDX_W'(0);
                    // Chain straight into the next frame when a byte is waiting.
                    if (!fifoEmpty_s) begin
                        fifoPop_s   = 1'b1;
                        shiftNext_s = fifoDout_s;
                        nextState_s = START;
                    end else begin
                        nextState_s = IDLE;
                    end
                end else begin
                    nextState_s = STOP;
                end
            end

            default: begin
                bitCntNext_s = CNT_W'(0);
                bitIdxNext_s = IDX_W'(0);
                nextState_s  = IDLE;
            end
        endcase
    end

    // Line level for the coming cycle, derived from where the FSM is heading.
    always_comb begin
        serialNext_s = 1'b1;
        case (nextState_s)
            START:   serialNext_s = 1'b0;
            DATA:    serialNext_s = shiftNext_s[0];
            STOP:    serialNext_s = 1'b1;
            IDLE:    serialNext_s = 1'b1;
            default: serialNext_s = 1'b1;
        endcase
    end

    // FSM state register; reset abandons any frame in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Bit-period counter, bit index and payload shift register.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            bitCnt_r <= CNT_W'(0);
            bitIdx_r <= IDX_W'(0);
            shift_r  <= {DATA_BITS{1'b0}};
        end else begin
            bitCnt_r <= bitCntNext_s;
            bitIdx_r <= bitIdxNext_s;
            shift_r  <= shiftNext_s;
        end
    end

    // Glitch-free line driver; returns high as soon as reset asserts.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            serialOut_r <= 1'b1;
        end else begin
            serialOut_r <= serialNext_s;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter at 4 clocks per bit. A frame-level reference
// model (byte queue plus position inside the current 40-cycle frame) predicts
// every output on every falling clock edge; directed table vectors and
// hand-written sequences add explicit checks for latency, back-to-back
// framing, full-buffer handling and reset in mid-frame.
module tb_uart_transmitter;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic       Clock;
    logic       Reset;
    logic [7:0] TxData;
    logic       TxValid;
    logic       TxReady;
    logic       SerialOut;
    logic       Busy;
    logic [2:0] FifoCount;

    int vectors;
    int miscompares;

    uart_transmitter #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .TxData    (TxData),
        .TxValid   (TxValid),
        .TxReady   (TxReady),
        .SerialOut (SerialOut),
        .Busy      (Busy),
        .FifoCount (FifoCount)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic       liveAtEdge = 1'b0;
    logic       vAtEdge    = 1'b0;
    logic [7:0] dAtEdge    = 8'h00;
    logic [7:0] mQ[$];
    logic [9:0] mFrame     = 10'h3ff;
    int         mPos       = -1;
    int         mBefore;
    logic       mPush;
    logic       expLine;

    always @(posedge Clock) begin
        liveAtEdge <= Reset;
        vAtEdge    <= TxValid;
        dAtEdge    <= TxData;
    end

    always @(negedge Clock) begin
        if (!Reset || !liveAtEdge) begin
            mPos = -1;
            mQ.delete();
        end else begin
            mBefore = mQ.size();
            mPush   = vAtEdge && (mBefore < DEPTH);
            if (mPos == -1 || mPos == FRAME - 1) begin
                if (mBefore > 0) begin
                    mFrame = {1'b1, mQ.pop_front(), 1'b0};
                    mPos   = 0;
                end else begin
                    mPos = -1;
                end
            end else begin
                mPos = mPos + 1;
            end
            if (mPush) mQ.push_back(dAtEdge);
        end
        expLine = (mPos < 0) ? 1'b1 : mFrame[mPos / CPB];
        check("model_serial", SerialOut, expLine);
        check("model_busy",   Busy, (mPos >= 0 || mQ.size() != 0));
        check("model_ready",  TxReady, (mQ.size() < DEPTH));
        check("model_count",  FifoCount, mQ.size());
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [7:0] data;
        logic [9:0] line;   // bit 0 = start bit, bit 9 = stop bit
    } vec_t;

    vec_t tbl[5];

    task automatic writeByte(input logic [7:0] b);
        @(negedge Clock);
        TxData  = b;
        TxValid = 1'b1;
        @(negedge Clock);
        TxValid = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int g;
        g = 0;
        while ((Busy !== 1'b0) && g < limit) begin
            @(negedge Clock);
            g++;
        end
        check("idle_wait", (g < limit), 1'b1);
    endtask

    initial begin
        int g;
        logic [7:0] seq[5];
        vectors     = 0;
        miscompares = 0;
        TxData      = 8'h00;
        TxValid     = 1'b0;
        Reset       = 1'b1;
        #1 Reset    = 1'b0;

        tbl[0] = '{8'hA5, 10'b1101001010};
        tbl[1] = '{8'h00, 10'b1000000000};
        tbl[2] = '{8'hFF, 10'b1111111110};
        tbl[3] = '{8'h3C, 10'b1001111000};
        tbl[4] = '{8'h81, 10'b1100000010};

        repeat (3) @(negedge Clock);
        check("reset_serial", SerialOut, 1'b1);
        check("reset_count",  FifoCount, 3'd0);
        #2 Reset = 1'b1;

        // Idle after reset: line high, nothing buffered.
        for (int i = 0; i < 100; i++) begin
            @(negedge Clock);
            check("idle_serial", SerialOut, 1'b1);
            check("idle_busy",   Busy, 1'b0);
            check("idle_ready",  TxReady, 1'b1);
            check("idle_count",  FifoCount, 3'd0);
        end

        // Single frames: exact line pattern, 2-cycle latency, Busy drop.
        for (int k = 0; k < 5; k++) begin
            waitIdle(200);
            writeByte(tbl[k].data);
            check("tbl_prestart", SerialOut, 1'b1);
            check("tbl_busy_queued", Busy, 1'b1);
            for (int j = 0; j < FRAME; j++) begin
                @(negedge Clock);
                check("tbl_line", SerialOut, tbl[k].line[j / CPB]);
                check("tbl_busy", Busy, 1'b1);
            end
            @(negedge Clock);
            check("tbl_busy_end", Busy, 1'b0);
            check("tbl_line_end", SerialOut, 1'b1);
        end

        // Five bytes with TxValid held high: fills buffer, frames back-to-back.
        seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C; seq[3] = 8'h81; seq[4] = 8'h55;
        @(negedge Clock);
        TxValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            TxData = seq[i];
            g = 0;
            while (!TxReady && g < 200) begin
                @(negedge Clock);
                g++;
            end
            check("ready_wait", (g < 200), 1'b1);
            @(negedge Clock);
            if (i == 1) check("pushpop_count", FifoCount, 3'd1);
        end
        check("full_ready", TxReady, 1'b0);
        check("full_count", FifoCount, 3'd4);
        // Writes offered while full must be dropped.
        TxData = 8'hEE;
        repeat (3) @(negedge Clock);
        check("full_ignored", FifoCount, 3'd4);
        TxValid = 1'b0;
        waitIdle(5 * FRAME + 50);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            @(negedge Clock);
            TxValid = ($urandom_range(0, 3) == 0);
            TxData  = 8'($urandom);
        end
        @(negedge Clock);
        TxValid = 1'b0;
        waitIdle(6 * FRAME + 50);

        // Reset during bit 3 of 0xF0 with another byte still queued.
        writeByte(8'hF0);
        writeByte(8'h11);
        g = 0;
        while (mPos != 17 && g < 100) begin
            @(negedge Clock);
            #1;
            g++;
        end
        check("reach_bit3", (g < 100), 1'b1);
        check("bit3_low",   SerialOut, 1'b0);
        check("bit3_queue", FifoCount, 3'd1);
        #1 Reset = 1'b0;
        #1;
        check("rst_serial", SerialOut, 1'b1);
        check("rst_count",  FifoCount, 3'd0);
        check("rst_busy",   Busy, 1'b0);
        check("rst_ready",  TxReady, 1'b1);
        @(negedge Clock);
        #2 Reset = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            check("post_rst_line", SerialOut, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog expired");
    end

endmodule
